load_store_unit: RTL and testbench

- Sits between the execute stage and the data memory port.
- Converts RV32I loads and stores (LB, LH, LW, LBU, LHU, SB, SH, SW) into word-wide accesses on the Memory block. Memory is word-addressed and has one-cycle registered read data.
- Sub-word stores use read-modify-write. Load results are sign- or zero-extended.
- One access in flight at a time. A start/done handshake lets the core stall.

---
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word accesses into word-wide memory cycles,
// using read-modify-write for sub-word stores. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  iStart,
    input  logic                  iStore,
    input  logic [2:0]            iFunct3,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic [DATA_WIDTH-1:0] iWriteData,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oFault,
    output logic [DATA_WIDTH-1:0] oReadData,
    output logic [ADDR_WIDTH-1:0] oMemAddress,
    output logic [DATA_WIDTH-1:0] oMemData,
    output logic                  oMemRead,
    output logic                  oMemWrite,
    input  logic [DATA_WIDTH-1:0] iMemData
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_store;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic                  r_done, r_fault;
    logic [DATA_WIDTH-1:0] r_rdata, r_mdata;

    logic                  w_accept, w_illegal, w_fault, w_is_sw;
    logic                  w_done_nxt, w_fault_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_eff;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [DATA_WIDTH-1:0] w_load_ext, w_merged;

    assign w_accept = (r_state == IDLE) && iStart;
    assign w_is_sw  = iStore && (iFunct3 == 3'b010);

    // Stores only have B/H/W encodings; loads additionally have BU/HU.
    always_comb begin
        w_illegal = 1'b0;
        if (iStore)
            w_illegal = iFunct3[2] || (iFunct3[1:0] == 2'b11);
        else
            w_illegal = (iFunct3 == 3'b011) || (iFunct3 == 3'b110) || (iFunct3 == 3'b111);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic w_misaligned;
    assign w_misaligned = ((iFunct3[1:0] == 2'b01) && iAddress[0]) ||
                          ((iFunct3[1:0] == 2'b10) && (iAddress[1:0] != 2'b00));
    assign w_fault      = w_illegal || w_misaligned;
    assign w_addr_eff   = iAddress;
`else
    // Without the trap, misaligned halves/words are aligned down and proceed.
    assign w_fault = w_illegal;
    always_comb begin
        w_addr_eff = iAddress;
        if (iFunct3[1:0] == 2'b01)
            w_addr_eff[0] = 1'b0;
        else if (iFunct3[1:0] == 2'b10)
            w_addr_eff[1:0] = 2'b00;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_fault_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (iStart) begin
                    if (w_fault) begin
                        w_done_nxt  = 1'b1;
                        w_fault_nxt = 1'b1;
                    end else if (w_is_sw) begin
                        w_state_nxt = WRITE;
                    end else begin
                        w_state_nxt = READ;
                    end
                end
            end
            READ:    w_state_nxt = CAPTURE;
            CAPTURE: begin
                if (r_store) begin
                    w_state_nxt = WRITE;
                end else begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            WRITE: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Little-endian lane select from the captured memory word.
    assign w_byte = iMemData[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = iMemData[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = iMemData;
        case (r_funct3)
            3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_ext = {24'h000000, w_byte};
            3'b101:  w_load_ext = {16'h0000, w_half};
            default: w_load_ext = iMemData;
        endcase
    end

    always_comb begin
        w_merged = iMemData;
        if (r_funct3[1:0] == 2'b00)
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        else
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
            r_rdata  <= '0;
            r_mdata  <= '0;
        end else begin
            r_done  <= w_done_nxt;
            r_fault <= w_fault_nxt;
            if (w_accept) begin
                r_store  <= iStore;
                r_funct3 <= iFunct3;
                r_addr   <= w_addr_eff;
                r_wdata  <= iWriteData[15:0];
                if (!w_fault && w_is_sw)
                    r_mdata <= iWriteData;
            end
            if (r_state == CAPTURE) begin
                if (r_store)
                    r_mdata <= w_merged;
                else
                    r_rdata <= w_load_ext;
            end
        end
    end

    // Memory strobes come straight from the state so reset kills them at once.
    assign oBusy       = (r_state != IDLE);
    assign oMemRead    = (r_state == READ);
    assign oMemWrite   = (r_state == WRITE);
    assign oMemAddress = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign oMemData    = r_mdata;
    assign oReadData   = r_rdata;
    assign oDone       = r_done;
    assign oFault      = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus hand sequences for
// back-to-back, busy-start and mid-write reset cases.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        iStart, iStore;
    logic [2:0]  iFunct3;
    logic [31:0] iAddress, iWriteData;
    logic        oBusy, oDone, oFault, oMemRead, oMemWrite;
    logic [31:0] oReadData, oMemAddress, oMemData, iMemData;

    logic [31:0] mem [0:255];
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_fault_wo_done = 0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n), .iStart(iStart), .iStore(iStore),
        .iFunct3(iFunct3), .iAddress(iAddress), .iWriteData(iWriteData),
        .oBusy(oBusy), .oDone(oDone), .oFault(oFault), .oReadData(oReadData),
        .oMemAddress(oMemAddress), .oMemData(oMemData), .oMemRead(oMemRead),
        .oMemWrite(oMemWrite), .iMemData(iMemData)
    );

    always #5 clock = ~clock;

    // Word-addressed memory with registered read data.
    always @(posedge clock) begin
        if (oMemRead)  iMemData <= mem[oMemAddress[9:2]];
        if (oMemWrite) mem[oMemAddress[9:2]] <= oMemData;
    end

    always @(negedge clock) if (oFault && !oDone) n_fault_wo_done++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; that cycle is cycle 0. Returns at the negedge where oDone is seen.
    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output int nrd, output int nwr);
        iStart = 1'b1; iStore = st; iFunct3 = f3; iAddress = a; iWriteData = wd;
        @(negedge clock);
        iStart = 1'b0;
        lat = 1; nrd = 0; nwr = 0;
        forever begin
            nrd += int'(oMemRead);
            nwr += int'(oMemWrite);
            if (oDone || lat >= 20) break;
            @(negedge clock);
            lat++;
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        flt;
        logic [31:0] rdata;
        int          nrd;
        int          nwr;
        logic [31:0] memw;
    } vec_t;

    localparam logic [31:0] A0 = 32'h1001_0000;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam logic [31:0] HELD = 32'h0000_0044;
    localparam logic [31:0] MW   = 32'hBEEF_3344;
`else
    localparam logic [31:0] HELD = 32'hBEEF_3344;
    localparam logic [31:0] MW   = 32'hBEEF_1234;
`endif

    vec_t v [15];

    initial begin
        int lat, nrd, nwr, extra;
        logic [31:0] tmp;

        v[0]  = '{1'b1, 3'b010, A0,       32'h1122_3344, 2, 1'b0, 32'h0,         0, 1, 32'h1122_3344};
        v[1]  = '{1'b0, 3'b010, A0,       32'h0,         3, 1'b0, 32'h1122_3344, 1, 0, 32'h1122_3344};
        v[2]  = '{1'b1, 3'b000, A0 + 3,   32'h0000_0080, 4, 1'b0, 32'h1122_3344, 1, 1, 32'h8022_3344};
        v[3]  = '{1'b0, 3'b000, A0 + 3,   32'h0,         3, 1'b0, 32'hFFFF_FF80, 1, 0, 32'h8022_3344};
        v[4]  = '{1'b0, 3'b100, A0 + 3,   32'h0,         3, 1'b0, 32'h0000_0080, 1, 0, 32'h8022_3344};
        v[5]  = '{1'b1, 3'b010, A0,       32'h1122_3344, 2, 1'b0, 32'h0000_0080, 0, 1, 32'h1122_3344};
        v[6]  = '{1'b1, 3'b001, A0 + 2,   32'h0000_BEEF, 4, 1'b0, 32'h0000_0080, 1, 1, 32'hBEEF_3344};
        v[7]  = '{1'b0, 3'b101, A0 + 2,   32'h0,         3, 1'b0, 32'h0000_BEEF, 1, 0, 32'hBEEF_3344};
        v[8]  = '{1'b0, 3'b001, A0 + 2,   32'h0,         3, 1'b0, 32'hFFFF_BEEF, 1, 0, 32'hBEEF_3344};
        v[9]  = '{1'b0, 3'b000, A0 + 1,   32'h0,         3, 1'b0, 32'h0000_0033, 1, 0, 32'hBEEF_3344};
        v[10] = '{1'b0, 3'b100, A0,       32'h0,         3, 1'b0, 32'h0000_0044, 1, 0, 32'hBEEF_3344};
`ifdef LSU_MISALIGN_TRAP_EN
        v[11] = '{1'b0, 3'b010, A0 + 2,   32'h0,         1, 1'b1, HELD,          0, 0, 32'hBEEF_3344};
        v[14] = '{1'b1, 3'b001, A0 + 1,   32'h0000_1234, 1, 1'b1, HELD,          0, 0, MW};
`else
        v[11] = '{1'b0, 3'b010, A0 + 2,   32'h0,         3, 1'b0, HELD,          1, 0, 32'hBEEF_3344};
        v[14] = '{1'b1, 3'b001, A0 + 1,   32'h0000_1234, 4, 1'b0, HELD,          1, 1, MW};
`endif
        v[12] = '{1'b0, 3'b011, A0,       32'h0,         1, 1'b1, HELD,          0, 0, 32'hBEEF_3344};
        v[13] = '{1'b1, 3'b100, A0,       32'h0000_00FF, 1, 1'b1, HELD,          0, 0, 32'hBEEF_3344};

        reset_n = 1'b0; iStart = 1'b0; iStore = 1'b0; iFunct3 = 3'b000;
        iAddress = '0; iWriteData = '0;
        repeat (3) @(negedge clock);
        chk("reset_ctrl", {27'd0, oBusy, oDone, oFault, oMemRead, oMemWrite}, 32'h0);
        chk("reset_rdata", oReadData, 32'h0);
        chk("reset_maddr", oMemAddress, 32'h0);
        chk("reset_mdata", oMemData, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            run(v[i].st, v[i].f3, v[i].addr, v[i].wdata, lat, nrd, nwr);
            chk($sformatf("v%0d_lat", i), lat, v[i].lat);
            chk($sformatf("v%0d_fault", i), {31'd0, oFault}, {31'd0, v[i].flt});
            chk($sformatf("v%0d_rdata", i), oReadData, v[i].rdata);
            chk($sformatf("v%0d_nrd", i), nrd, v[i].nrd);
            chk($sformatf("v%0d_nwr", i), nwr, v[i].nwr);
            @(negedge clock);
            chk($sformatf("v%0d_mem", i), mem[0], v[i].memw);
        end
        chk("mem_addr", oMemAddress, A0);

        // New request issued in the very cycle oDone is high.
        @(negedge clock);
        run(1'b0, 3'b010, A0, 32'h0, lat, nrd, nwr);
        chk("b2b_first", oReadData, MW);
        run(1'b0, 3'b100, A0 + 3, 32'h0, lat, nrd, nwr);
        chk("b2b_lat", lat, 3);
        chk("b2b_rdata", oReadData, 32'h0000_00BE);

        // iStart during busy must be ignored (it would fault if accepted).
        @(negedge clock);
        iStart = 1'b1; iStore = 1'b0; iFunct3 = 3'b010; iAddress = A0;
        @(negedge clock);
        chk("busy_hi", {31'd0, oBusy}, 32'd1);
        iFunct3 = 3'b011;
        @(negedge clock);
        iStart = 1'b0;
        lat = 2;
        while (!oDone && lat < 20) begin @(negedge clock); lat++; end
        chk("busy_lat", lat, 3);
        chk("busy_fault", {31'd0, oFault}, 32'd0);
        chk("busy_rdata", oReadData, MW);
        extra = 0;
        repeat (6) begin @(negedge clock); extra += int'(oDone); end
        chk("busy_extra_done", extra, 0);

        // Reset asserted during the WRITE state of an SB.
        iStart = 1'b1; iStore = 1'b1; iFunct3 = 3'b000; iAddress = A0 + 1; iWriteData = 32'hAA;
        @(negedge clock);
        iStart = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_in_write", {31'd0, oMemWrite}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_wr_drop", {30'd0, oMemWrite, oBusy}, 32'd0);
        @(negedge clock);
        chk("rst_no_done", {31'd0, oDone}, 32'd0);
        chk("rst_mem", mem[0], MW);
        chk("rst_rdata", oReadData, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        run(1'b0, 3'b100, A0 + 1, 32'h0, lat, nrd, nwr);
        chk("post_rst_lat", lat, 3);
        tmp = MW >> 8;
        chk("post_rst_rdata", oReadData, {24'd0, tmp[7:0]});

        chk("fault_wo_done", n_fault_wo_done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
